// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider (N >= 2).
// Produces a registered divided clock and a one-cycle period-start strobe,
// with count enable, synchronous restart and divisor reload at boundaries.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable; low freezes the divider
//   restart   in   synchronous restart of the current period
//   div_load  in   one-cycle request to load div_in
//   div_in    in   requested divisor N (WIDTH bits)
//   clk_out   out  divided clock, high ceil(N/2) / low floor(N/2) cycles
//   tick      out  one-cycle pulse on each period start
//   div_cur   out  divisor currently in effect
//   div_pend  out  a loaded divisor waits for the next boundary
//   div_err   out  one-cycle pulse; last div_load was rejected (N < 2)
module clk_div_prog #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             div_pend,
  output logic             div_err
);

  // Extra bit keeps (cur_div + 1) and (cnt + 1) exact at N = 2^WIDTH-1.
  localparam int unsigned WX = WIDTH + 1;
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] cur_div_q,  cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             div_pend_q, div_pend_d;
  logic             running_q,  running_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;
  logic             div_err_q,  div_err_d;

  logic [WX-1:0]    hi;
  logic [WX-1:0]    cnt_inc;
  logic             at_end;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cur_div_q  <= DIV_RST;
      pend_div_q <= '0;
      div_pend_q <= 1'b0;
      running_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      div_pend_q <= div_pend_d;
      running_q  <= running_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      div_err_q  <= div_err_d;
    end
  end

  // Next-state: restart > period start > count; divisor load handled last
  // so a load coinciding with a period start stays pending (set wins).
  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    div_pend_d = div_pend_q;
    running_d  = running_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    div_err_d  = 1'b0;

    hi      = (WX'(cur_div_q) + WX'(1)) >> 1;
    cnt_inc = WX'(cnt_q) + WX'(1);
    at_end  = (cnt_q == (cur_div_q - WIDTH'(1)));

    if (restart) begin
      running_d = 1'b0;
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (en) begin
      if (!running_q || at_end) begin
        if (div_pend_q) begin
          cur_div_d  = pend_div_q;
          div_pend_d = 1'b0;
        end
        cnt_d     = '0;
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
        running_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + WIDTH'(1);
        clk_out_d = (cnt_inc < hi);
      end
    end

    if (div_load) begin
      if (div_in >= WIDTH'(2)) begin
        pend_div_d = div_in;
        div_pend_d = 1'b1;
      end else begin
        div_err_d  = 1'b1;
      end
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign div_cur  = cur_div_q;
  assign div_pend = div_pend_q;
  assign div_err  = div_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        rst_n, en, restart, div_load;
  logic [15:0] div_in;
  logic        clk_out, tick, div_pend, div_err;
  logic [15:0] div_cur;

  logic        en2;
  logic        rs2, ld2;
  logic [3:0]  din2;
  logic        clk_out2, tick2, div_pend2, div_err2;
  logic [3:0]  div_cur2;

  always #5 clk = ~clk;

  clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(100)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .div_load(div_load), .div_in(div_in),
    .clk_out(clk_out), .tick(tick), .div_cur(div_cur),
    .div_pend(div_pend), .div_err(div_err)
  );

  clk_div_prog #(.WIDTH(4), .DEFAULT_DIV(15)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en2), .restart(rs2),
    .div_load(ld2), .div_in(din2),
    .clk_out(clk_out2), .tick(tick2), .div_cur(div_cur2),
    .div_pend(div_pend2), .div_err(div_err2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        co;
    logic        tk;
    logic [15:0] dc;
    logic        dp;
    logic        de;
  } exp_t;
  exp_t sb[$];

  // Behavioural reference of the divider, written from the waveform rules.
  int   m_cnt, m_cur, m_pend;
  logic m_pp, m_run, m_out, m_tick, m_err;
  int   cyc;
  int   tick_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_cur = 100; m_pend = 0;
    m_pp = 0; m_run = 0; m_out = 0; m_tick = 0; m_err = 0;
  endtask

  function automatic logic will_start();
    return en && !restart && (!m_run || m_cnt == m_cur - 1);
  endfunction

  task automatic model_edge();
    m_err = 0;
    if (restart) begin
      m_run = 0; m_cnt = 0; m_out = 0; m_tick = 0;
    end else if (en) begin
      if (!m_run || m_cnt == m_cur - 1) begin
        if (m_pp) begin
          m_cur = m_pend;
          m_pp  = 0;
        end
        m_cnt = 0; m_out = 1; m_tick = 1; m_run = 1;
      end else begin
        m_cnt  = m_cnt + 1;
        m_out  = (m_cnt < (m_cur + 1) / 2);
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
    if (div_load) begin
      if (int'(div_in) >= 2) begin
        m_pend = int'(div_in);
        m_pp   = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  // One clock edge: push the predicted outputs, then pop and compare.
  task automatic step();
    exp_t e;
    model_edge();
    e.co = m_out; e.tk = m_tick; e.dc = 16'(m_cur); e.dp = m_pp; e.de = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (tick) tick_cyc.push_back(cyc);
    e = sb.pop_front();
    chk("sb_clk_out",  32'(clk_out),  32'(e.co));
    chk("sb_tick",     32'(tick),     32'(e.tk));
    chk("sb_div_cur",  32'(div_cur),  32'(e.dc));
    chk("sb_div_pend", 32'(div_pend), 32'(e.dp));
    chk("sb_div_err",  32'(div_err),  32'(e.de));
  endtask

  initial begin
    int   hi;
    int   n;
    logic pat_co [6];
    logic pat_tk [6];
    pat_co = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pat_tk = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 0; en = 0; restart = 0; div_load = 0; div_in = '0;
    en2 = 0; rs2 = 0; ld2 = 0; din2 = '0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out",  32'(clk_out),  0);
    chk("rst_tick",     32'(tick),     0);
    chk("rst_div_cur",  32'(div_cur),  100);
    chk("rst_div_pend", 32'(div_pend), 0);
    chk("rst_div_err",  32'(div_err),  0);
    chk("rst_div_cur4", 32'(div_cur2), 15);

    // Default N=100 with a load of 3 at cycle 40
    rst_n = 1; en = 1;
    hi = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 40) begin div_load = 1; div_in = 16'd3; end
      step();
      div_load = 0;
      if (clk_out) hi++;
      if (i == 1) chk("first_tick", 32'(tick), 1);
    end
    chk("n100_high_cycles", 32'(hi), 50);
    chk("n100_pend_held", 32'(div_pend), 1);
    chk("n100_cur_held", 32'(div_cur), 100);
    chk("n100_tick_count", 32'(tick_cyc.size()), 1);
    step();
    chk("boundary_tick", 32'(tick), 1);
    chk("boundary_div_cur", 32'(div_cur), 3);
    chk("boundary_div_pend", 32'(div_pend), 0);
    chk("boundary_tick_cycle", 32'(tick_cyc.size() > 1 ? tick_cyc[1] : 0), 101);

    // N=3 waveform 1,1,0
    for (int k = 0; k < 6; k++) begin
      step();
      chk("n3_clk_out", 32'(clk_out), 32'(pat_co[k]));
      chk("n3_tick", 32'(tick), 32'(pat_tk[k]));
    end

    // Rejected loads
    div_load = 1; div_in = 16'd1;
    step();
    div_load = 0;
    chk("err_load1", 32'(div_err), 1);
    step();
    chk("err_one_cycle", 32'(div_err), 0);
    div_load = 1; div_in = 16'd0;
    step();
    div_load = 0;
    chk("err_load0", 32'(div_err), 1);
    chk("err_div_cur", 32'(div_cur), 3);
    chk("err_div_pend", 32'(div_pend), 0);

    // Load on a period-start edge applies one period later
    n = 0;
    while (!will_start() && n < 10) begin step(); n++; end
    div_load = 1; div_in = 16'd5;
    step();
    div_load = 0;
    chk("tickload_tick", 32'(tick), 1);
    chk("tickload_cur", 32'(div_cur), 3);
    chk("tickload_pend", 32'(div_pend), 1);
    repeat (3) step();
    chk("tickload_next_tick", 32'(tick), 1);
    chk("tickload_applied", 32'(div_cur), 5);
    chk("tickload_pend_clr", 32'(div_pend), 0);

    // Freeze 7 cycles in the high phase of N=5
    step();
    en = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("freeze_clk_out", 32'(clk_out), 1);
      chk("freeze_tick", 32'(tick), 0);
    end
    en = 1;
    n = 0;
    do begin step(); n++; end while (!tick && n < 10);
    chk("freeze_resume_edges", 32'(n), 4);

    // Restart at cnt=20 with N=100
    div_load = 1; div_in = 16'd100;
    step();
    div_load = 0;
    n = 0;
    do begin step(); n++; end while (!tick && n < 10);
    chk("restart_div_cur", 32'(div_cur), 100);
    n = 0;
    while (m_cnt != 20 && n < 30) begin step(); n++; end
    chk("restart_cnt_reached", 32'(m_cnt), 20);
    restart = 1;
    step();
    restart = 0;
    chk("restart_clk_out", 32'(clk_out), 0);
    chk("restart_tick", 32'(tick), 0);
    step();
    chk("restart_new_clk_out", 32'(clk_out), 1);
    chk("restart_new_tick", 32'(tick), 1);

    // Async reset mid-period with a pending load
    div_load = 1; div_in = 16'd7;
    step();
    div_load = 0;
    repeat (3) step();
    chk("pre_reset_pend", 32'(div_pend), 1);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    chk("areset_clk_out",  32'(clk_out),  0);
    chk("areset_tick",     32'(tick),     0);
    chk("areset_div_cur",  32'(div_cur),  100);
    chk("areset_div_pend", 32'(div_pend), 0);
    chk("areset_div_err",  32'(div_err),  0);

    // WIDTH=4, N=15: period 15, high 8 / low 7
    @(posedge clk);
    #1;
    rst_n = 1; en = 0; en2 = 1;
    hi = 0;
    tick_cyc.delete();
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i <= 15 && clk_out2) hi++;
      if (i == 1)  chk("n15_first_tick", 32'(tick2), 1);
      if (i == 16) chk("n15_second_tick", 32'(tick2), 1);
      if (i > 1 && i < 16 && tick2) chk("n15_no_early_tick", 32'(i), 16);
    end
    chk("n15_high_cycles", 32'(hi), 8);
    chk("n15_div_cur", 32'(div_cur2), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Parametrised, runtime-programmable clock divider. Derives a slow clock (`clk_out`) and a one-cycle period strobe (`tick`) from `clk` by any integer ratio N ≥ 2. It adds enable/freeze, synchronous restart, and glitch-free divisor reload at period boundaries. It serves as the general timebase source for slow peripherals (blinkers, debouncers, display scanning), all in the `clk` domain.

## Interface
- `WIDTH`, 16, bit width of divisor and internal counter; maximum N = 2^WIDTH−1.
- `DEFAULT_DIV`, 100, divisor after reset; must satisfy 2 ≤ DEFAULT_DIV < 2^WIDTH.

- `clk`  in  1  system clock, rising edge. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  count enable; low freezes the divider.
- `restart`  in  1  synchronous restart of the current period.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_in`  in  WIDTH  requested divisor N.
- `clk_out`  out  1  divided clock (registered).
- `tick`  out  1  one-cycle pulse on each period start.
- `div_cur`  out  WIDTH  divisor currently in effect.
- `div_pend`  out  1  a loaded divisor is waiting for the next boundary.
- `div_err`  out  1  one-cycle pulse; the last `div_load` was rejected.

## Operation
- Internal state: `cnt`, `cur_div`, `pend_div`, `div_pend`, `running`. `HI = ceil(cur_div/2)`, computed as `(cur_div+1)>>1` at WIDTH+1 bits.
- Reset (async, `rst_n`=0) sets:
  - `cnt`=0, `cur_div`=DEFAULT_DIV, `pend_div`=0, `div_pend`=0, `running`=0.
  - `clk_out`=0, `tick`=0, `div_err`=0.
- Priority at each edge is restart > en.
- **restart**=1: `running`←0, `cnt`←0, `clk_out`←0, `tick`←0. This happens regardless of `en`. The pending divisor is kept.
- **en**=1, restart=0, and (`running`=0 or `cnt`=`cur_div`−1) is a period start:
  - If `div_pend`, then `cur_div`←`pend_div` and `div_pend`←0.
  - `cnt`←0, `clk_out`←1, `tick`←1, `running`←1.
- **en**=1, otherwise: `cnt`←`cnt`+1, `clk_out`←(`cnt`+1 < HI), `tick`←0.
- **en**=0: `cnt`, `clk_out` and `running` hold, and `tick`←0. Restart still acts while en=0.
- **div_load** is independent of `en` and `restart`:
  - If `div_in` ≥ 2: `pend_div`←`div_in`, `div_pend`←1. A later load overwrites an earlier pending one.
  - If `div_in` < 2: `div_err`←1 for one cycle, and `pend_div`/`div_pend` are unchanged.
- Load on the same edge as a period start: the period starts with the previous `pend_div`/`cur_div`. The new value stays pending (set wins over clear) and applies at the following boundary.
- Resulting waveform: period exactly N enabled cycles. `clk_out` is high for ceil(N/2) cycles and low for floor(N/2) cycles. N=100 gives 50/50, N=3 gives 2 high / 1 low, N=2 gives 1/1.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- First enabled edge after reset release (or after restart) drives `clk_out`=1 and `tick`=1 (latency 1 edge).
- Subsequent `tick` pulses come every N enabled edges and are coincident with the `clk_out` rising transition.
- Divisor change latency: the new value takes effect at the first period start strictly after the load edge. It never truncates or stretches the current period.
- `div_err` is asserted the cycle after the rejected load edge.
- Reset asserted mid-period returns all outputs to reset values immediately (async). The pending divisor is discarded.
- Wrap-around: `cnt` never exceeds `cur_div`−1, so no overflow at N=2^WIDTH−1.

## Test plan
- Default N=100, en=1 after reset: `clk_out` high 50 / low 50 cycles; `tick` at cycles 1, 101, 201; `div_cur`=100.
- Load `div_in`=3 at cycle 40:
  - `div_pend`=1 until the next boundary at cycle 101.
  - Thereafter `clk_out` follows the pattern 1,1,0 and `tick` occurs every 3 cycles.
  - `div_cur`=3 and `div_pend`=0.
- Load `div_in`=1, then `div_in`=0: `div_err` pulses once per load and the divisor is unchanged. Load on a `tick` edge: applies one period later.
- Drop en for 7 cycles mid-high-phase: `clk_out` and `cnt` frozen, no `tick`; the period completes 7 cycles late with the duty cycle intact.
- Restart at cnt=20 with en=1:
  - Next edge: `clk_out`=0, `tick`=0.
  - Edge after that: `clk_out`=1, `tick`=1 (new period).
- Async reset mid-period with a pending load: all outputs return to reset values at once; `div_cur`=DEFAULT_DIV, `div_pend`=0. Also check N=2^WIDTH−1 with WIDTH=4: period 15, high 8 / low 7.
